n_bit_serial_subtractor: RTL and testbench
==========================================

// Module: n_bit_serial_subtractor
// PURPOSE
//  Bit-serial M-bit subtractor: the inverse operation of N_bit_adder. Captures
//  operands a and b through a valid/ready handshake and processes one bit per
//  clock, LSB first. Presents diff = a - b (mod 2^M) and borrow = (a < b)
//  through an output valid/ready handshake. Used to check adder results
//  (c - b == a) and as a low-area subtract path in the same datapath.
// PARAMETERS
//  M   4   operand/result width in bits, M >= 1; counter width = $clog2(M+1)
// PORTS
//  clk        in   1  single clock; all state updates on rising edge
//  rst        in   1  synchronous, active-high reset
//  in_valid   in   1  operands a/b valid
//  in_ready   out  1  block can accept operands (IDLE only)
//  a          in   M  minuend
//  b          in   M  subtrahend
//  out_valid  out  1  diff/borrow valid (DONE only)
//  out_ready  in   1  consumer accepts result
//  diff       out  M  a - b modulo 2^M
//  borrow     out  1  1 when a < b (unsigned)
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE, in_ready=1, out_valid=0, diff=0,
//   borrow=0, bit counter=0, operand shift regs=0. Reset wins over all inputs.
//  FSM states: IDLE, RUN, DONE.
//  IDLE: in_ready=1. If in_valid at an edge, latch a,b into shift regs,
//   clear borrow_r=0, clear cnt=0, go to RUN. No other action.
//  RUN: in_ready=0, out_valid=0. Each cycle, full-subtractor on
//   (a_sh[0], b_sh[0], borrow_r) gives d, bo. Shift d into diff at the MSB
//   (right shift), shift a_sh/b_sh right, borrow_r<=bo, cnt<=cnt+1.
//   When cnt==M-1, go to DONE at that edge.
//  DONE: out_valid=1, diff/borrow stable. borrow = final borrow_r.
//   On out_ready, go to IDLE at that edge.
//  Latency: out_valid rises exactly M cycles after the acceptance edge.
//   Minimum throughput is 1 op per M+2 cycles.
//  in_valid outside IDLE is ignored; a/b are sampled only at acceptance.
//  out_ready outside DONE is ignored. diff/borrow keep their last value in
//   IDLE. They may change in RUN; the consumer samples them only when
//   out_valid=1.
//  M=1: RUN lasts one cycle.
//  Reset during RUN or DONE: the operation is discarded and no result is
//   emitted.
//  Arithmetic: unsigned, full-subtractor d = x^y^bi,
//   bo = (~x&y) | (~(x^y)&bi).
// STRUCTURE
//  Shared package sub_pkg: state encoding constants S_IDLE=2'd0, S_RUN=2'd1,
//   S_DONE=2'd2.
//  One sub-module: full_subtractor (x, y, bin -> d, bout), combinational,
//   instantiated once.
//  Top: FSM, counter, shift registers, output registers.
// TESTING
//  1) M=4, a=9, b=3, out_ready=1 -> out_valid M=4 cycles after accept,
//     diff=6, borrow=0.
//  2) a=3, b=9 -> diff=4'hA, borrow=1. a=0, b=0 -> diff=0, borrow=0.
//     a=15, b=15 -> diff=0, borrow=0. a=0, b=1 -> diff=4'hF, borrow=1.
//  3) Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and diff
//     is stable. in_valid pulses in that window are ignored; in_ready=0.
//  4) Assert rst at RUN cycle 2 -> next cycle IDLE, in_ready=1, out_valid=0,
//     and no result is emitted.
//  5) Back-to-back: in_valid held high with new operands -> second accept
//     in the cycle after the DONE handshake.
//  6) Random 1000 ops, M=4 and M=8 -> diff==(a-b)&mask, borrow==(a<b),
//     and adder round-trip N_bit_adder(diff, b)==a.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/n_bit_serial_subtractor_if.sv
// Operand/result bus of the bit-serial subtractor.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// 1; the source holds its payload stable while valid=1 and ready=0.
interface n_bit_serial_subtractor_if #(
  parameter int M = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] diff;
  logic         borrow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow
  );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, bout set when that underflows.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/n_bit_serial_subtractor.sv
// Bit-serial M-bit subtractor: one bit per clock, LSB first, result and final
// borrow presented through a valid/ready output handshake.
module n_bit_serial_subtractor
  import sub_pkg::*;
#(
  parameter int M = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  n_bit_serial_subtractor_if.slave    bus,
  output state_t                      dbg_state
);
  localparam int CW = $clog2(M + 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [M-1:0]   a_sh, b_sh, diff_q, diff_next;
  logic           borrow_r;
  logic           fs_d, fs_bout;

  full_subtractor u_fs (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (borrow_r),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // New result bit enters at the MSB so that after M shifts bit 0 sits at the LSB.
  always_comb begin
    diff_next        = diff_q >> 1;
    diff_next[M-1]   = fs_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_RUN;
      S_RUN:   if (cnt_q == CW'(M - 1)) state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      diff_q   <= '0;
      borrow_r <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_sh     <= bus.a;
            b_sh     <= bus.b;
            borrow_r <= 1'b0;
            cnt_q    <= '0;
          end
        end
        S_RUN: begin
          diff_q   <= diff_next;
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          borrow_r <= fs_bout;
          cnt_q    <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_r;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_n_bit_serial_subtractor.sv
// Bench for n_bit_serial_subtractor: directed steps then random ops on M=4 and M=8.
module tb_n_bit_serial_subtractor;
  import sub_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // two instances: M=4 (sel 0) and M=8 (sel 1)
  n_bit_serial_subtractor_if #(.M(4)) bus4 ();
  n_bit_serial_subtractor_if #(.M(8)) bus8 ();
  state_t dbg4, dbg8;

  n_bit_serial_subtractor #(.M(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave), .dbg_state(dbg4));
  n_bit_serial_subtractor #(.M(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave), .dbg_state(dbg8));

  logic       iv4 = 1'b0, ordy4 = 1'b0, iv8 = 1'b0, ordy8 = 1'b0;
  logic [3:0] ia4 = '0, ib4 = '0;
  logic [7:0] ia8 = '0, ib8 = '0;
  assign bus4.in_valid = iv4;  assign bus4.a = ia4;  assign bus4.b = ib4;  assign bus4.out_ready = ordy4;
  assign bus8.in_valid = iv8;  assign bus8.a = ia8;  assign bus8.b = ib8;  assign bus8.out_ready = ordy8;

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];   // {borrow, diff}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] get_diff(input int sel);
    return (sel != 0) ? bus8.diff : {4'b0, bus4.diff};
  endfunction
  function automatic logic get_borrow(input int sel);
    return (sel != 0) ? bus8.borrow : bus4.borrow;
  endfunction
  function automatic logic get_ov(input int sel);
    return (sel != 0) ? bus8.out_valid : bus4.out_valid;
  endfunction
  function automatic logic get_ir(input int sel);
    return (sel != 0) ? bus8.in_ready : bus4.in_ready;
  endfunction

  // driver tasks
  task automatic set_in(input int sel, input logic v, input logic [7:0] av, input logic [7:0] bv);
    if (sel != 0) begin iv8 = v; ia8 = av; ib8 = bv; end
    else begin iv4 = v; ia4 = av[3:0]; ib4 = bv[3:0]; end
  endtask
  task automatic set_ordy(input int sel, input logic v);
    if (sel != 0) ordy8 = v; else ordy4 = v;
  endtask

  // One operation. armed=1: in_valid is already high at the current negedge.
  // nv=1: raise in_valid with next operands in the same cycle as the result handshake.
  task automatic run_op(input int sel, input logic [7:0] av_i, input logic [7:0] bv_i,
                        input int stall, input bit pulse, input bit armed,
                        input bit nv, input logic [7:0] na, input logic [7:0] nb);
    int w;
    int lat;
    logic [7:0] mask, av, bv, snap, rd;
    logic [8:0] e;
    w    = (sel != 0) ? 8 : 4;
    mask = (sel != 0) ? 8'hFF : 8'h0F;
    av   = av_i & mask;
    bv   = bv_i & mask;
    e[7:0] = (av - bv) & mask;
    e[8]   = (av < bv);
    exp_q.push_back(e);
    if (!armed) begin
      @(negedge clk);
      set_in(sel, 1'b1, av, bv);
    end
    check("in_ready_idle", 32'(get_ir(sel)), 32'd1);
    @(posedge clk);
    @(negedge clk);
    set_in(sel, 1'b0, 8'h00, 8'h00);
    lat = 0;
    while (!get_ov(sel) && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", 32'(lat), 32'(w));
    snap = get_diff(sel);
    for (int i = 0; i < stall; i++) begin
      if (pulse) set_in(sel, i[0], 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      @(posedge clk);
      @(negedge clk);
      check("hold_out_valid", 32'(get_ov(sel)), 32'd1);
      check("hold_diff", 32'(get_diff(sel)), 32'(snap));
      if (pulse) check("hold_in_ready", 32'(get_ir(sel)), 32'd0);
    end
    if (pulse) set_in(sel, 1'b0, 8'h00, 8'h00);
    set_ordy(sel, 1'b1);
    if (nv) set_in(sel, 1'b1, na, nb);
    e  = exp_q.pop_front();
    rd = get_diff(sel);
    check("diff", 32'(rd), 32'(e[7:0]));
    check("borrow", 32'(get_borrow(sel)), 32'(e[8]));
    check("round_trip", 32'((rd + bv) & mask), 32'(av));
    @(posedge clk);
    @(negedge clk);
    set_ordy(sel, 1'b0);
    check("post_out_valid", 32'(get_ov(sel)), 32'd0);
    check("post_in_ready", 32'(get_ir(sel)), 32'd1);
  endtask

  initial begin
    logic [7:0] ta [4];
    logic [7:0] tb [4];
    int lat;
    int seen;
    ta = '{8'd3, 8'd0, 8'd15, 8'd0};
    tb = '{8'd9, 8'd0, 8'd15, 8'd1};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready4", 32'(bus4.in_ready), 32'd1);
    check("rst_out_valid4", 32'(bus4.out_valid), 32'd0);
    check("rst_diff4", 32'(bus4.diff), 32'd0);
    check("rst_borrow4", 32'(bus4.borrow), 32'd0);
    check("rst_state4", 32'(dbg4), 32'(S_IDLE));
    check("rst_in_ready8", 32'(bus8.in_ready), 32'd1);
    check("rst_diff8", 32'(bus8.diff), 32'd0);

    // 9 - 3
    run_op(0, 8'd9, 8'd3, 0, 0, 0, 0, 0, 0);
    // corner operands
    for (int i = 0; i < 4; i++) run_op(0, ta[i], tb[i], 0, 0, 0, 0, 0, 0);
    // stall in DONE with in_valid pulses
    run_op(0, 8'd12, 8'd5, 5, 1, 0, 0, 0, 0);

    // reset during RUN cycle 2
    @(negedge clk);
    set_in(0, 1'b1, 8'd14, 8'd2);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 8'h00, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check("run_before_rst", 32'(dbg4), 32'(S_RUN));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_run_in_ready", 32'(bus4.in_ready), 32'd1);
    check("rst_run_out_valid", 32'(bus4.out_valid), 32'd0);
    check("rst_run_state", 32'(dbg4), 32'(S_IDLE));
    check("rst_run_diff", 32'(bus4.diff), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus4.out_valid) seen++;
    end
    check("rst_no_result", 32'(seen), 32'd0);

    // back-to-back: second accept the cycle after the DONE handshake
    run_op(0, 8'd7, 8'd2, 0, 0, 0, 1, 8'd2, 8'd7);
    check("b2b_state_idle", 32'(dbg4), 32'(S_IDLE));
    run_op(0, 8'd2, 8'd7, 0, 0, 1, 0, 0, 0);

    // random operations on both widths
    for (int i = 0; i < 1000; i++)
      run_op(0, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
             $urandom_range(0, 2), 0, 0, 0, 0, 0);
    for (int i = 0; i < 1000; i++)
      run_op(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             $urandom_range(0, 2), 0, 0, 0, 0, 0);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    lat = 0;

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
